sram_rd_slave: RTL and testbench

- Read-only AXI-style responder for the on-chip 8 KiB SRAM window at 0x0f000000–0x0f001fff.
- Answers the fetch unit's AR/R requests (one outstanding at a time) with 64-bit doubleword data.
- The requester picks the 32-bit half by addr[2]; this block always returns the full doubleword.
- A 32-bit side-load port fills the array before and while the core runs.

---
 rtl/sram_rd_slave_pkg.sv | 16 +
 rtl/sram_rd_array.sv | 31 +++
 rtl/sram_rd_slave.sv | 124 ++++++++++++
 tb/tb_sram_rd_slave.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_rd_slave_pkg.sv
// Shared response codes, FSM state encoding and counter width for the SRAM read slave.
package sram_rd_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Wide enough for LATENCY-1 (max 14) plus up to 7 random extra cycles.
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/sram_rd_array.sv
// DEPTH x 64 SRAM with a registered (synchronous) read port and a 32-bit half-word write port.
module sram_rd_array #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic                     wr_hi,
    input  logic [31:0]              wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [63:0]              rd_data
);

    logic [31:0] mem_lo [DEPTH];
    logic [31:0] mem_hi [DEPTH];
    logic [63:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en && !wr_hi) mem_lo[wr_idx] <= wr_data;
        if (wr_en &&  wr_hi) mem_hi[wr_idx] <= wr_data;
    end

    // A write to the entry being read in the same cycle returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data_q <= {mem_hi[rd_idx], mem_lo[rd_idx]};
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sram_rd_slave.sv
// Read-only AXI-style responder for the on-chip SRAM window, one outstanding read at a time.
// Optional SRAM_RD_RANDOM_DELAY_EN: LFSR-gated arready and 0..7 extra wait cycles.
//
// state | meaning
// IDLE  | arready high, waiting for an AR handshake
// WAIT  | latency countdown; array read issued when the counter hits 0
// RESP  | rvalid high, rdata/rresp held until rready
module sram_rd_slave
    import sram_rd_slave_pkg::*;
#(
    parameter logic [31:0] BASE    = 32'h0f000000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_slave_arvalid,
    output logic        io_slave_arready,
    input  logic [31:0] io_slave_araddr,
    output logic        io_slave_rvalid,
    input  logic        io_slave_rready,
    output logic [1:0]  io_slave_rresp,
    output logic [63:0] io_slave_rdata,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [32:0] WIN_END = {1'b0, BASE} + 33'(DEPTH * 8);

    function automatic logic in_window(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < WIN_END);
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_load;
    logic [AW-1:0]    idx_q;
    logic             okay_q;
    logic [1:0]       resp_q;
    logic             ar_hs, rd_fire, wr_en;
    logic [AW-1:0]    wr_idx;
    logic [63:0]      arr_rdata;

`ifdef SRAM_RD_RANDOM_DELAY_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 16'hACE1;
        else      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[3:1]);
`else
    assign cnt_load = CNT_W'(LATENCY - 1);
`endif

    assign ar_hs   = io_slave_arvalid && io_slave_arready;
    assign rd_fire = (state_q == WAIT) && (cnt_q == '0);
    assign wr_en   = ld_en && in_window(ld_addr);
    assign wr_idx  = AW'((ld_addr - BASE) >> 3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_hs) state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (io_slave_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            okay_q <= 1'b0;
            resp_q <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                cnt_q  <= cnt_load;
                idx_q  <= AW'((io_slave_araddr - BASE) >> 3);
                okay_q <= in_window(io_slave_araddr);
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (rd_fire) resp_q <= okay_q ? RESP_OKAY : RESP_DECERR;
        end
    end

    always_comb begin
        io_slave_arready = (state_q == IDLE);
`ifdef SRAM_RD_RANDOM_DELAY_EN
        io_slave_arready = (state_q == IDLE) && lfsr_q[0];
`endif
        io_slave_rvalid  = (state_q == RESP);
        io_slave_rresp   = RESP_OKAY;
        io_slave_rdata   = '0;
        if (state_q == RESP) begin
            io_slave_rresp = resp_q;
            // Out-of-window reads never enable the array, so mask its stale output.
            if (resp_q == RESP_OKAY) io_slave_rdata = arr_rdata;
        end
    end

    sram_rd_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_hi   (ld_addr[2]),
        .wr_data (ld_data),
        .rd_en   (rd_fire && okay_q),
        .rd_idx  (idx_q),
        .rd_data (arr_rdata)
    );

endmodule

// File: tb/tb_sram_rd_slave.sv
// Randomized bench for sram_rd_slave: LATENCY=1 and LATENCY=4 instances share stimulus.
module tb_sram_rd_slave;

    localparam logic [31:0] BASE = 32'h0f000000;
    localparam int          LAT_A = 1;
    localparam int          LAT_B = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        arvalid, rready, ld_en;
    logic [31:0] araddr, ld_addr, ld_data;

    logic        a_arready, a_rvalid, b_arready, b_rvalid;
    logic [1:0]  a_rresp, b_rresp;
    logic [63:0] a_rdata, b_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mem_m [int];

    always #5 clk = ~clk;

    sram_rd_slave #(.BASE(BASE), .DEPTH(1024), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .io_slave_arvalid(arvalid), .io_slave_arready(a_arready), .io_slave_araddr(araddr),
        .io_slave_rvalid(a_rvalid), .io_slave_rready(rready),
        .io_slave_rresp(a_rresp), .io_slave_rdata(a_rdata),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    sram_rd_slave #(.BASE(BASE), .DEPTH(1024), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .io_slave_arvalid(arvalid), .io_slave_arready(b_arready), .io_slave_araddr(araddr),
        .io_slave_rvalid(b_rvalid), .io_slave_rready(rready),
        .io_slave_rresp(b_rresp), .io_slave_rdata(b_rdata),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h2000);
    endfunction

    function automatic logic [63:0] model_rd(input logic [31:0] a);
        int idx;
        if (!in_win(a)) return 64'h0;
        idx = int'((a - BASE) / 8);
        return mem_m.exists(idx) ? mem_m[idx] : 64'h0;
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        logic [63:0] cur;
        int idx;
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
        if (in_win(a)) begin
            idx = int'((a - BASE) / 8);
            cur = mem_m.exists(idx) ? mem_m[idx] : 64'h0;
            if (a[2]) cur[63:32] = d;
            else      cur[31:0]  = d;
            mem_m[idx] = cur;
        end
    endtask

    // Full read on both instances with rready held high; optional side-load to the
    // same entry in the cycle right after the handshake (the short instance's read cycle).
    task automatic do_read(input string tag, input logic [31:0] a, input bit collide);
        logic [63:0] exp_a, exp_b;
        logic [1:0]  exp_r;
        int lat_a = 99;
        int lat_b = 99;
        int n = 1;
        exp_a = model_rd(a);
        exp_r = in_win(a) ? 2'b00 : 2'b11;
        check({tag, ":ar_ready"}, {a_arready, b_arready}, 2'b11);
        arvalid = 1'b1; araddr = a; rready = 1'b1;
        tick();
        arvalid = 1'b0; araddr = $urandom;
        if (collide) begin
            load({a[31:2], 2'b00}, $urandom);
            n = 2;
        end
        exp_b = model_rd(a);
        for (; n <= 12; n++) begin
            if (a_rvalid && lat_a == 99) begin
                lat_a = n;
                check({tag, ":a_rdata"}, a_rdata, exp_a);
                check({tag, ":a_rresp"}, a_rresp, exp_r);
            end
            if (lat_a != 99 && n == lat_a + 1)
                check({tag, ":a_after"}, {a_arready, a_rvalid}, 2'b10);
            if (b_rvalid && lat_b == 99) begin
                lat_b = n;
                check({tag, ":b_rdata"}, b_rdata, exp_b);
                check({tag, ":b_rresp"}, b_rresp, exp_r);
            end
            if (lat_b != 99 && n == lat_b + 1)
                check({tag, ":b_after"}, {b_arready, b_rvalid}, 2'b10);
            tick();
        end
        check({tag, ":a_latency"}, lat_a, LAT_A + 1);
        check({tag, ":b_latency"}, lat_b, LAT_B + 1);
    endtask

    // Called just after a posedge: drops rst mid-cycle and checks outputs asynchronously.
    task automatic reset_pulse(input string tag);
        #3 rst = 1'b0;
        #1;
        check({tag, ":a_ready_valid"}, {a_arready, a_rvalid}, 2'b10);
        check({tag, ":b_ready_valid"}, {b_arready, b_rvalid}, 2'b10);
        check({tag, ":a_resp_data"}, {a_rresp, a_rdata}, 66'h0);
        check({tag, ":b_resp_data"}, {b_rresp, b_rdata}, 66'h0);
        #2 rst = 1'b1;
        tick();
    endtask

    initial begin
        logic [63:0] exp_d;
        logic [31:0] a;
        int e;
        rst = 1'b0; arvalid = 1'b0; rready = 1'b1; ld_en = 1'b0;
        araddr = '0; ld_addr = '0; ld_data = '0;
        tick();
        check("reset:a", {a_arready, a_rvalid, a_rresp, a_rdata}, {1'b1, 1'b0, 66'h0});
        check("reset:b", {b_arready, b_rvalid, b_rresp, b_rdata}, {1'b1, 1'b0, 66'h0});
        tick();
        rst = 1'b1;
        tick();
        reset_pulse("rst_idle");

        load(BASE, 32'h00000413);
        load(BASE + 32'h4, 32'h00100093);
        check("basic:model", model_rd(BASE + 32'h4), 64'h00100093_00000413);
        do_read("basic", BASE + 32'h4, 1'b0);

        // Backpressure: both responses pending, rready low, competing AR refused.
        rready = 1'b0; arvalid = 1'b1; araddr = BASE + 32'h4;
        tick();
        arvalid = 1'b0;
        repeat (4) tick();
        exp_d = model_rd(BASE);
        for (int i = 0; i < 5; i++) begin
            arvalid = 1'b1; araddr = BASE + 32'h8;
            check("bp:a_hold", {a_arready, a_rvalid, a_rresp, a_rdata}, {1'b0, 1'b1, 2'b00, exp_d});
            check("bp:b_hold", {b_arready, b_rvalid, b_rresp, b_rdata}, {1'b0, 1'b1, 2'b00, exp_d});
            tick();
        end
        arvalid = 1'b0; rready = 1'b1;
        tick();
        check("bp:release", {a_arready, a_rvalid, b_arready, b_rvalid}, 4'b1010);

        do_read("decerr_hi", 32'h0f002000, 1'b0);
        do_read("decerr_lo", 32'h0effffff, 1'b0);

        load(32'h0f001ff8, 32'hcafef00d);
        load(32'h0f001ffc, 32'h12345678);
        do_read("last_entry", 32'h0f001ff8, 1'b0);

        load(32'h0f002000, 32'hdeadbeef);
        load(32'h0f002004, 32'hdeadbeef);
        load(32'h0efffffc, 32'hbadc0de0);
        do_read("ld_oow_ignored", BASE + 32'h3, 1'b0);

        do_read("collide", BASE + 32'h4, 1'b1);

        arvalid = 1'b1; araddr = BASE;
        tick();
        arvalid = 1'b0;
        reset_pulse("rst_wait");
        arvalid = 1'b1; araddr = BASE;
        tick();
        arvalid = 1'b0;
        tick();
        check("pre_rst_resp:a_rvalid", a_rvalid, 1'b1);
        reset_pulse("rst_resp");
        do_read("after_rst", BASE, 1'b0);

        for (int it = 0; it < 25; it++) begin
            e = $urandom_range(0, 1023);
            a = BASE + 32'(e * 8);
            load(a, $urandom);
            load(a + 32'h4, $urandom);
            do_read($sformatf("rnd%0d_in", it), a + 32'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) a = BASE + 32'h2000 + 32'($urandom_range(0, 32'h00ffffff));
            else                           a = BASE - 32'd1 - 32'($urandom_range(0, 32'h0000ffff));
            do_read($sformatf("rnd%0d_out", it), a, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
